// File: rtl/dmem_uart_tx.sv
`default_nettype none
// ============================================================================
// dmem_uart_tx : memory-mapped 8N1 UART transmitter on the CPU data port
// Revision     : 1.0
// ============================================================================
module dmem_uart_tx #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] BASE    = XLEN'(32'h0001_0000),
   parameter int              DEPTH   = 4,
   parameter logic [15:0]     DEF_DIV = 16'd16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [XLEN-1:0]   mem_addr,
   input  logic [XLEN-1:0]   mem_din,
   input  logic [XLEN/8-1:0] mem_w,
   input  logic [XLEN/8-1:0] mem_r,
   output logic [XLEN-1:0]   mem_dout,
   output logic              sel,
   output logic              txd
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic          hit;
   logic [3:0]    off;
   logic          wr_txdata, wr_status;
   logic          push_ok, ser_pop;
   logic          full, empty, busy;
   logic          bit_end;
   logic [XLEN-1:0] reg_val;
   logic [31:0]   status;

   state_t        state_q, state_d;
   logic          txd_q, txd_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   div_reg_q, div_reg_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    fifo_mem [DEPTH];

   logic          unused_ok;
   assign unused_ok = ^{mem_din[XLEN-1:16], mem_w[XLEN/8-1:2]};

   assign hit       = (mem_addr[XLEN-1:4] == BASE[XLEN-1:4]);
   assign off       = mem_addr[3:0];
   assign sel       = hit;
   assign wr_txdata = hit && (off == 4'h0) && mem_w[0];
   assign wr_status = hit && (off == 4'h4) && mem_w[0];

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign busy    = (state_q != IDLE);
   assign push_ok = wr_txdata && (!full || ser_pop);
   assign bit_end = (cnt_q == div_q - 16'd1);
   assign txd     = txd_q;

   assign status = {16'h0000, 8'(count_q), 4'h0, ovf_q, busy, empty, full};

   always_comb begin
      reg_val = '0;
      case (off)
         4'h4:    reg_val = XLEN'(status);
         4'h8:    reg_val = XLEN'(div_reg_q);
         default: reg_val = '0;
      endcase
      mem_dout = '0;
      if (hit) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (mem_r[i]) mem_dout[i*8 +: 8] = reg_val[i*8 +: 8];
         end
      end
   end

   // Serializer next-state; a pop (from IDLE or end of STOP) overrides and restarts the frame.
   always_comb begin
      state_d = state_q;
      txd_d   = txd_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      div_d   = div_q;
      ser_pop = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (!empty) ser_pop = 1'b1;
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
               txd_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (!empty) begin
                  ser_pop = 1'b1;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            cnt_d   = '0;
         end
      endcase
      if (ser_pop) begin
         shift_d = fifo_mem[rd_ptr_q];
         div_d   = (div_reg_q == 16'd0) ? 16'd1 : div_reg_q;
         state_d = START;
         txd_d   = 1'b0;
         cnt_d   = '0;
      end
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q;
      div_reg_d = div_reg_q;
      count_d   = count_q + CW'(push_ok) - CW'(ser_pop);
      if (push_ok)
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (ser_pop)
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      if (wr_txdata && !push_ok)
         ovf_d = 1'b1;
      else if (wr_status && mem_din[3])
         ovf_d = 1'b0;
      if (hit && (off == 4'h8)) begin
         if (mem_w[0]) div_reg_d[7:0]  = mem_din[7:0];
         if (mem_w[1]) div_reg_d[15:8] = mem_din[15:8];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         txd_q     <= 1'b1;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         div_q     <= '0;
         div_reg_q <= DEF_DIV;
         ovf_q     <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         txd_q     <= txd_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         div_q     <= div_d;
         div_reg_q <= div_reg_d;
         ovf_q     <= ovf_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // Storage needs no reset: count and pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= mem_din[7:0];
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_dmem_uart_tx : directed bench with a frame-level waveform model
// Revision        : 1.0
// ============================================================================
module tb_dmem_uart_tx;

   localparam logic [31:0] BASE    = 32'h0001_0000;
   localparam int          DEPTH   = 4;
   localparam logic [15:0] DEF_DIV = 16'd16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_din = '0;
   logic [3:0]  mem_w = '0;
   logic [3:0]  mem_r = '0;
   logic [31:0] mem_dout;
   logic        sel;
   logic        txd;

   int checks = 0;
   int errors = 0;

   dmem_uart_tx #(.XLEN(32), .BASE(BASE), .DEPTH(DEPTH), .DEF_DIV(DEF_DIV)) dut (
      .clk(clk), .rstn(rstn), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_w(mem_w), .mem_r(mem_r), .mem_dout(mem_dout), .sel(sel), .txd(txd)
   );

   always #5 clk = ~clk;

   // Model: FIFO of bytes plus a queue of per-cycle txd levels for frames in flight.
   logic [7:0]  m_fifo[$];
   bit          m_wave[$];
   bit          m_txd = 1'b1;
   bit          m_busy = 1'b0;
   bit          m_ovf = 1'b0;
   logic [15:0] m_div = DEF_DIV;
   int          m_busy_cycles = 0;
   int          m_pops = 0;

   function automatic bit in_win(input logic [31:0] a);
      return (a & 32'hFFFF_FFF0) == BASE;
   endfunction

   task automatic model_step();
      logic [7:0] b;
      int d;
      bit lvl;
      if (!rstn) begin
         m_fifo.delete(); m_wave.delete();
         m_txd = 1'b1; m_busy = 1'b0; m_ovf = 1'b0; m_div = DEF_DIV;
         return;
      end
      if (m_wave.size() == 0 && m_fifo.size() > 0) begin
         b = m_fifo.pop_front();
         m_pops++;
         d = (m_div == 16'd0) ? 1 : int'(m_div);
         for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < d; j++) m_wave.push_back(lvl);
         end
      end
      if (in_win(mem_addr)) begin
         if (mem_addr[3:0] == 4'h0 && mem_w[0]) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(mem_din[7:0]);
            else m_ovf = 1'b1;
         end
         if (mem_addr[3:0] == 4'h4 && mem_w[0] && mem_din[3]) m_ovf = 1'b0;
         if (mem_addr[3:0] == 4'h8) begin
            if (mem_w[0]) m_div[7:0]  = mem_din[7:0];
            if (mem_w[1]) m_div[15:8] = mem_din[15:8];
         end
      end
      if (m_wave.size() > 0) begin
         m_txd = m_wave.pop_front(); m_busy = 1'b1; m_busy_cycles++;
      end else begin
         m_txd = 1'b1; m_busy = 1'b0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      model_step();
   end

   function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] r);
      logic [31:0] v;
      logic [31:0] o;
      v = '0; o = '0;
      if (!in_win(a)) return '0;
      if (a[3:0] == 4'h4)
         v = {16'h0, 8'(m_fifo.size()), 4'h0, m_ovf, m_busy,
              (m_fifo.size() == 0), (m_fifo.size() == DEPTH)};
      else if (a[3:0] == 4'h8)
         v = {16'h0, m_div};
      for (int i = 0; i < 4; i++) if (r[i]) o[i*8 +: 8] = v[i*8 +: 8];
      return o;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of the serial line and window decode.
   initial forever begin
      @(negedge clk);
      #4;
      chk("txd_cycle", {31'h0, txd}, {31'h0, m_txd});
      chk("sel_cycle", {31'h0, sel}, {31'h0, in_win(mem_addr)});
   end

   task automatic rd(input logic [31:0] a, input logic [3:0] r,
                     output logic [31:0] d, output logic [31:0] m, output logic s);
      mem_addr = a; mem_r = r;
      #1;
      d = mem_dout; s = sel; m = model_read(a, r);
      mem_r = '0; mem_addr = '0;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [3:0] r,
                         input logic [31:0] lit);
      logic [31:0] d, m;
      logic s;
      rd(a, r, d, m, s);
      chk({nm, "_model"}, d, m);
      chk({nm, "_lit"}, d, lit);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      @(negedge clk);
      mem_addr = a; mem_din = d; mem_w = w;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      mem_addr = '0; mem_din = '0; mem_w = '0;
   endtask

   task automatic wait_idle(input int limit, input string nm);
      int t;
      t = 0;
      while (m_busy || m_fifo.size() != 0 || txd !== 1'b1) begin
         @(negedge clk);
         t++;
         if (t > limit) begin
            checks++; errors++;
            $display("FAIL %s: timeout after %0d cycles", nm, limit);
            return;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int bc, pc, t;
      logic [9:0] fv;
      logic [31:0] d, m;
      logic s;

      // 1: reset state
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      rd_chk("rst_status", BASE + 4, 4'hF, 32'h0000_0002);
      chk("rst_txd", {31'h0, txd}, 32'h1);
      rd_chk("rst_div", BASE + 8, 4'hF, 32'h0000_0010);

      // 2: single 0x55 frame at DIV=4
      wr(BASE + 8, 32'h4, 4'b0011);
      wr(BASE + 0, 32'h55, 4'b0001);
      bus_idle();
      t = 0;
      forever begin
         @(negedge clk); #2;
         if (txd === 1'b0) break;
         t++;
         if (t > 20) begin
            checks++; errors++;
            $display("FAIL start_bit: txd never went low");
            break;
         end
      end
      fv = '0;
      for (int sidx = 1; sidx < 40; sidx++) begin
         @(negedge clk); #2;
         if (sidx % 4 == 2) fv[sidx/4] = txd;
         if (sidx == 39) rd_chk("frame_last_status", BASE + 4, 4'hF, 32'h0000_0006);
      end
      chk("frame_55_bits", {22'h0, fv}, 32'h0000_02AA);
      @(negedge clk); #2;
      chk("frame_end_txd", {31'h0, txd}, 32'h1);
      rd_chk("after_55_status", BASE + 4, 4'hF, 32'h0000_0002);

      // DIV=0 behaves as 1: ten-clock frame
      wr(BASE + 8, 32'h0, 4'b0011);
      bc = m_busy_cycles;
      wr(BASE + 0, 32'h81, 4'b0001);
      bus_idle();
      wait_idle(100, "div0_idle");
      chk("div0_frame_len", m_busy_cycles - bc, 32'd10);

      // 3: three back-to-back frames
      wr(BASE + 8, 32'h4, 4'b0011);
      bc = m_busy_cycles;
      wr(BASE + 0, 32'h41, 4'b0001);
      wr(BASE + 0, 32'h42, 4'b0001);
      wr(BASE + 0, 32'h43, 4'b0001);
      bus_idle();
      rd_chk("b2b_status", BASE + 4, 4'hF, 32'h0000_0204);
      wait_idle(400, "b2b_idle");
      chk("b2b_len", m_busy_cycles - bc, 32'd120);

      // 4: overflow with DIV=100
      wr(BASE + 8, 32'd100, 4'b0011);
      bc = m_busy_cycles; pc = m_pops;
      for (int i = 0; i < 6; i++) wr(BASE + 0, 32'h60 + i, 4'b0001);
      bus_idle();
      rd_chk("ovf_status", BASE + 4, 4'hF, 32'h0000_040D);
      wr(BASE + 4, 32'h8, 4'b0001);
      bus_idle();
      rd_chk("ovf_clr_status", BASE + 4, 4'hF, 32'h0000_0405);
      wait_idle(8000, "ovf_idle");
      chk("ovf_pops", m_pops - pc, 32'd5);
      chk("ovf_len", m_busy_cycles - bc, 32'd5000);

      // byte-lane masking and individual DIV lane writes
      wr(BASE + 8, 32'hFFFF_1234, 4'b0011);
      bus_idle();
      rd_chk("div_lane0", BASE + 8, 4'b0001, 32'h0000_0034);
      rd_chk("div_lane1", BASE + 8, 4'b0010, 32'h0000_1200);
      wr(BASE + 8, 32'h0000_AB00, 4'b0010);
      bus_idle();
      rd_chk("div_hi_write", BASE + 8, 4'hF, 32'h0000_AB34);
      rd_chk("no_rd_en", BASE + 8, 4'h0, 32'h0);
      rd_chk("txdata_read", BASE + 0, 4'hF, 32'h0);

      // 6: out-of-window access
      @(negedge clk);
      rd(BASE + 32'h20, 4'hF, d, m, s);
      chk("oow_sel", {31'h0, s}, 32'h0);
      chk("oow_dout", d, 32'h0);
      wr(BASE + 32'h20, 32'h77, 4'hF);
      bus_idle();
      rd_chk("oow_status", BASE + 4, 4'hF, 32'h0000_0002);
      repeat (5) @(negedge clk);

      // 5: reset mid-DATA
      wr(BASE + 8, 32'h4, 4'b0011);
      wr(BASE + 0, 32'hA5, 4'b0001);
      bus_idle();
      repeat (12) @(negedge clk);
      #3 rstn = 1'b0;
      #1 chk("rst_mid_txd", {31'h0, txd}, 32'h1);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      rd_chk("rst_mid_status", BASE + 4, 4'hF, 32'h0000_0002);
      rd_chk("rst_mid_div", BASE + 8, 4'hF, 32'h0000_0010);
      repeat (60) @(negedge clk);
      rd_chk("rst_mid_quiet", BASE + 4, 4'hF, 32'h0000_0002);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/dmem_uart_tx.md
Name: dmem_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the CPU core.
- Decodes a 16-byte window of the CPU's byte-enabled load/store bus (mem_addr/mem_din/mem_w/mem_r/mem_dout).
- Buffers store bytes in a FIFO and serializes them as 8N1 frames on txd.
- Loads outside the window see zero; the system data RAM is muxed in using sel.

Parameters:
- XLEN, 32: CPU data width. Must be at least 32.
- BASE, 32'h0001_0000: window base address. Must be 16-byte aligned.
- DEPTH, 4: TX FIFO entries. Power of two, at most 128.
- DEF_DIV, 16'd16: reset value of the DIV register, in clocks per bit.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- mem_addr  in  XLEN  CPU data address.
- mem_din  in  XLEN  store data; byte lane i is [i*8+:8].
- mem_w  in  XLEN/8  store byte enables.
- mem_r  in  XLEN/8  load byte enables.
- mem_dout  out  XLEN  load data, combinational.
- sel  out  1  high when mem_addr is in the window, combinational.
- txd  out  1  serial output; idle level is 1.

Behaviour:
- Decode:
  - hit = (mem_addr[XLEN-1:4] == BASE[XLEN-1:4]); sel = hit.
  - off = mem_addr[3:0]; only the word offsets 0x0, 0x4 and 0x8 are defined.
- Writes are sampled on the rising clk edge while hit and mem_w is nonzero.
- Reads:
  - mem_dout is the selected register masked per byte lane by mem_r.
  - mem_dout = 0 when !hit, or when no mem_r bit is set.
- Registers:
  - 0x0 TXDATA
    - Write with mem_w[0] pushes mem_din[7:0] into the FIFO. Other lanes are ignored.
    - Reads return 0.
  - 0x4 STATUS
    - Read fields: bit0 full; bit1 empty; bit2 busy (FSM not IDLE); bit3 ovf (sticky); bits[15:8] FIFO count.
    - Write with mem_w[0] and mem_din[3]=1 clears ovf.
  - 0x8 DIV
    - 16-bit R/W; lanes 0 and 1 are writable individually.
    - The value 0 is treated as 1.
- FIFO:
  - A push is accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and ovf is set; ovf and the FIFO contents are otherwise unchanged.
  - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
  - A simultaneous push and pop leaves count unchanged and preserves order.
- Serializer FSM (states IDLE, START, DATA, STOP):
  - IDLE: txd=1. If the FIFO is not empty: pop into shift register, latch DIV into div_q, go to START.
  - START: txd=0 for div_q clocks.
  - DATA: txd=shift[0], LSB first. Each bit lasts div_q clocks; 8 bits, then STOP.
  - STOP: txd=1 for div_q clocks.
    - At the end of STOP, if the FIFO is not empty: pop and latch DIV, then go directly to START (no idle cycle).
    - Otherwise go to IDLE.
  - A DIV write mid-frame affects only the next frame.
  - txd is registered. The first START clock begins the cycle after the pop edge.
  - Frame length is exactly 10*div_q clocks.
- Reset state (asynchronous, immediate, including mid-frame):
  - txd=1; FSM=IDLE; FIFO empty (count=0).
  - ovf=0; DIV=DEF_DIV; bit counter and divider counter are 0.
  - A partially sent frame is abandoned.
- mem_dout and sel are combinational, so they follow their inputs during reset.

Test Plan:
1. Reset, then read STATUS (mem_r=4'hF, addr BASE+4) -> 0x0000_0002 (empty); txd=1; DIV reads 16.
2. Write DIV=4, then store 0x55 to BASE+0 -> txd shows 4 clocks 0, then data bits 1,0,1,0,1,0,1,0 (4 clocks each), then 4 clocks 1. Total 40 clocks; busy=1 throughout; afterwards STATUS=0x0000_0002.
3. DIV=4; store 0x41, 0x42, 0x43 back-to-back -> three contiguous frames of 120 clocks total with no idle gap. After the first pop, STATUS count=2.
4. DEPTH=4, DIV=100; store 6 bytes on consecutive cycles:
   - Expected: 1 popped, 4 queued, 1 dropped.
   - STATUS bit0=1, bit3=1, count=4.
   - Write 0x8 to STATUS -> bit3 clears; only the 5 accepted bytes are transmitted.
5. Deassert rstn mid-DATA of a frame -> txd=1 immediately; STATUS reads 0x0000_0002 after release; no residual frame is sent.
6. Load from BASE+0x20 (out of window) with mem_r=4'hF -> sel=0, mem_dout=0. Store to the same address -> no FIFO change.
